spi_reg_slave: RTL and testbench

- Parametrised SPI slave register port for the `top` design; the next generation of the `spi_clk`/`spi_mosi`/`spi_miso`/`spi_cs` interface.
- Oversamples the SPI pins in the `clk` domain and decodes frames of the form command word, then N data words.
- Produces register-file write strobes and read requests with auto-incrementing addresses, and shifts read data back on MISO.
- Adds to the existing interface: configurable word width, all four SPI modes, read-back, and abort detection.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_slave.sv | 186 ++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register slave: FSM states,
// command-word decoding constant and SPI-mode edge selection.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    // Value of the command word's MSB that selects a read transaction.
    localparam logic CMD_RD_BIT = 1'b1;

    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the synchronised level in the clk domain.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave register port: oversamples the SPI pins, decodes a command word
// followed by data words, and issues auto-incrementing register strobes.
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int WORD_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              frame_active,
    output logic              frame_err
);

    localparam int              CNT_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic            SAMPLE_RISE = sample_on_rise(CPOL[0], CPHA[0]);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);

    logic sck_level_s, sck_rise_s, sck_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic mosi_level_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .d_i(spi_clk),
        .level_o(sck_level_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(spi_cs),
        .level_o(cs_level_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_mosi),
        .level_o(mosi_level_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s));

    assign unused_s = ^{sck_level_s, mosi_rise_s, mosi_fall_s};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [WORD_W-1:0] rx_q, tx_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              armed_q, wd_q, end_q, frame_err_q, rd_pend_q;
    logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              sample_s, shift_s, active_s, word_done_s;

    assign sample_s    = SAMPLE_RISE ? sck_rise_s : sck_fall_s;
    assign shift_s     = SAMPLE_RISE ? sck_fall_s : sck_rise_s;
    assign active_s    = (state_q != IDLE);
    assign word_done_s = active_s & sample_s & (bit_cnt_q == LAST_BIT);

    // Bit/word datapath; armed_q ignores a frame already running when reset releases
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            wd_q        <= 1'b0;
            end_q       <= 1'b0;
            frame_err_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            bit_cnt_q   <= {CNT_W{1'b0}};
            rx_q        <= {WORD_W{1'b0}};
            tx_q        <= {WORD_W{1'b0}};
        end else begin
            armed_q     <= armed_q | cs_level_s;
            wd_q        <= word_done_s;
            end_q       <= active_s & cs_rise_s;
            frame_err_q <= active_s & cs_rise_s & (bit_cnt_q != {CNT_W{1'b0}}) & ~word_done_s;
            rd_pend_q   <= rd_en_q;
            if (cs_rise_s || cs_fall_s)
                bit_cnt_q <= {CNT_W{1'b0}};
            else if (active_s && sample_s)
                bit_cnt_q <= word_done_s ? {CNT_W{1'b0}} : bit_cnt_q + CNT_W'(1);
            if (active_s && sample_s)
                rx_q <= {rx_q[WORD_W-2:0], mosi_level_s};
            // The shift edge at a word boundary is skipped: the new MSB is already loaded
            if (cs_fall_s)
                tx_q <= {WORD_W{1'b0}};
            else if (rd_pend_q)
                tx_q <= rd_data;
            else if (active_s && shift_s && (bit_cnt_q != {CNT_W{1'b0}}))
                tx_q <= {tx_q[WORD_W-2:0], 1'b0};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (cs_fall_s && armed_q) ? CMD : IDLE;
            CMD: begin
                if (end_q)     state_d = IDLE;
                else if (wd_q) state_d = (rx_q[WORD_W-1] == CMD_RD_BIT) ? RDATA : WDATA;
                else           state_d = CMD;
            end
            WDATA:   state_d = end_q ? IDLE : WDATA;
            RDATA:   state_d = end_q ? IDLE : RDATA;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: strobes and address sequencing on each completed word
    always_comb begin
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = {ADDR_W{1'b0}};
        wr_data_d = {WORD_W{1'b0}};
        rd_en_d   = 1'b0;
        rd_addr_d = {ADDR_W{1'b0}};
        if (wd_q) begin
            case (state_q)
                CMD: begin
                    addr_d = rx_q[ADDR_W-1:0];
                    if (rx_q[WORD_W-1] == CMD_RD_BIT) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = rx_q[ADDR_W-1:0];
                    end else begin
                        rd_en_d   = 1'b0;
                    end
                end
                WDATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_q;
                    addr_d    = addr_q + ADDR_W'(1);
                end
                RDATA: begin
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q + ADDR_W'(1);
                end
                default: addr_d = addr_q;
            endcase
        end else begin
            addr_d = addr_q;
        end
    end

    // Registered strobe outputs and running address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= {ADDR_W{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {WORD_W{1'b0}};
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
        end else begin
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign frame_err    = frame_err_q;
    assign spi_miso     = tx_q[WORD_W-1];
    assign frame_active = armed_q & ~cs_level_s;
    assign spi_miso_oe  = armed_q & ~cs_level_s;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: mode 0 / 8-bit and mode 3 / 16-bit instances.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sclk0, cs0, mosi0, miso0, oe0, wr_en0, rd_en0, fa0, fe0;
    logic [6:0]  wr_addr0, rd_addr0;
    logic [7:0]  wr_data0;
    logic [7:0]  rd_data0 = 8'h00;
    logic        sclk3, cs3, mosi3, miso3, oe3, wr_en3, rd_en3, fa3, fe3;
    logic [7:0]  wr_addr3, rd_addr3;
    logic [15:0] wr_data3;
    logic [15:0] rd_data3 = 16'h0000;

    spi_reg_slave #(.WORD_W(8), .ADDR_W(7), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs(cs0), .spi_mosi(mosi0),
        .spi_miso(miso0), .spi_miso_oe(oe0), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .frame_active(fa0), .frame_err(fe0));

    spi_reg_slave #(.WORD_W(16), .ADDR_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rst(rst), .spi_clk(sclk3), .spi_cs(cs3), .spi_mosi(mosi3),
        .spi_miso(miso3), .spi_miso_oe(oe3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .frame_active(fa3), .frame_err(fe3));

    // Register file model: read data is the address XOR 0x55, one clk after rd_en
    always @(posedge clk) begin
        if (rd_en0) rd_data0 <= {1'b0, rd_addr0} ^ 8'h55;
    end

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_wr0[$];
    logic [31:0] exp_rd0[$];
    logic [31:0] exp_err0[$];
    logic [31:0] exp_wr3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: actual %h required no event", name, act);
    endtask

    // Monitor: every strobe the DUTs present is matched against the scoreboard
    always @(negedge clk) begin
        if (wr_en0) begin
            if (exp_wr0.size() == 0) unexpected("wr0", {16'(wr_addr0), 16'(wr_data0)});
            else chk("wr0", {16'(wr_addr0), 16'(wr_data0)}, exp_wr0.pop_front());
        end
        if (rd_en0) begin
            if (exp_rd0.size() == 0) unexpected("rd0", 32'(rd_addr0));
            else chk("rd0", 32'(rd_addr0), exp_rd0.pop_front());
        end
        if (fe0) begin
            if (exp_err0.size() == 0) unexpected("err0", 32'(fe0));
            else chk("err0", 32'(fe0), exp_err0.pop_front());
        end
        if (wr_en3) begin
            if (exp_wr3.size() == 0) unexpected("wr3", {16'(wr_addr3), wr_data3});
            else chk("wr3", {16'(wr_addr3), wr_data3}, exp_wr3.pop_front());
        end
        if (rd_en3 || fe3) unexpected("rd_err3", {30'd0, rd_en3, fe3});
    end

    task automatic word0(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi0 = tx[7-i];
            #HALF;
            sclk0 = 1'b1;
            rx = {rx[6:0], miso0};
            #HALF;
            sclk0 = 1'b0;
        end
    endtask

    task automatic frame0(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int nw);
        logic [7:0] r;
        cs0 = 1'b0;
        #HALF;
        word0(w0, 8, r);
        word0(w1, 8, r);
        if (nw > 2) word0(w2, 8, r);
        #HALF;
        cs0 = 1'b1;
        #(4*HALF);
    endtask

    task automatic word3(input logic [15:0] tx);
        for (int i = 0; i < 16; i++) begin
            #HALF;
            sclk3 = 1'b0;
            mosi3 = tx[15-i];
            #HALF;
            sclk3 = 1'b1;
        end
    endtask

    task automatic push_wr0(input logic [15:0] a, input logic [15:0] d);
        exp_wr0.push_back({a, d});
    endtask

    logic [7:0] r0;

    initial begin
        sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
        sclk3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0;
        #23;
        chk("reset_outs0", 32'({wr_en0, rd_en0, fa0, fe0, miso0, oe0, wr_addr0, rd_addr0, wr_data0}), 32'h0);
        chk("reset_outs3", 32'({wr_en3, rd_en3, fa3, fe3, miso3, oe3}), 32'h0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_frame_active", 32'({fa0, oe0}), 32'h0);

        // Mode 0 write burst with address increment
        push_wr0(16'h05, 16'hA5);
        push_wr0(16'h06, 16'h3C);
        cs0 = 1'b0;
        #HALF;
        word0(8'h05, 8, r0);
        chk("frame_active_mid", 32'({fa0, oe0}), 32'h3);
        word0(8'hA5, 8, r0);
        word0(8'h3C, 8, r0);
        #HALF;
        cs0 = 1'b1;
        #(4*HALF);
        chk("frame_active_end", 32'({fa0, oe0}), 32'h0);

        // Read burst with prefetch; MISO returns addr ^ 0x55
        exp_rd0.push_back(32'h01);
        exp_rd0.push_back(32'h02);
        exp_rd0.push_back(32'h03);
        cs0 = 1'b0;
        #HALF;
        word0(8'h81, 8, r0);
        chk("miso_cmd", 32'(r0), 32'h00);
        word0(8'h00, 8, r0);
        chk("miso_w1", 32'(r0), 32'h54);
        word0(8'h00, 8, r0);
        chk("miso_w2", 32'(r0), 32'h57);
        #HALF;
        cs0 = 1'b1;
        #(4*HALF);

        // Address wrap 0x7F -> 0x00
        push_wr0(16'h7F, 16'h11);
        push_wr0(16'h00, 16'h22);
        frame0(8'h7F, 8'h11, 8'h22, 3);

        // Abort after 5 bits of the second data word
        push_wr0(16'h10, 16'h99);
        exp_err0.push_back(32'h1);
        cs0 = 1'b0;
        #HALF;
        word0(8'h10, 8, r0);
        word0(8'h99, 8, r0);
        word0(8'h77, 5, r0);
        #HALF;
        cs0 = 1'b1;
        #(4*HALF);
        chk("err_consumed", 32'(exp_err0.size()), 32'h0);
        push_wr0(16'h20, 16'h5A);
        frame0(8'h20, 8'h5A, 8'h00, 2);

        // Mode 3, 16-bit words
        exp_wr3.push_back({16'h0012, 16'hBEEF});
        cs3 = 1'b0;
        #HALF;
        word3(16'h0012);
        word3(16'hBEEF);
        #HALF;
        cs3 = 1'b1;
        #(4*HALF);

        // Reset mid-WDATA; remaining bits of that frame must be ignored
        push_wr0(16'h30, 16'h01);
        cs0 = 1'b0;
        #HALF;
        word0(8'h30, 8, r0);
        word0(8'h01, 8, r0);
        word0(8'hFF, 3, r0);
        rst = 1'b0;
        #1;
        chk("midreset_outs0", 32'({wr_en0, rd_en0, fa0, fe0, miso0, oe0, wr_addr0, rd_addr0, wr_data0}), 32'h0);
        repeat (4) @(posedge clk);
        rst = 1'b1;
        word0(8'hFF, 5, r0);
        chk("post_reset_ignored", 32'({fa0, oe0}), 32'h0);
        #HALF;
        cs0 = 1'b1;
        #(4*HALF);
        push_wr0(16'h40, 16'h66);
        frame0(8'h40, 8'h66, 8'h00, 2);

        repeat (20) @(posedge clk);
        chk("wr0_pending", 32'(exp_wr0.size()), 32'h0);
        chk("rd0_pending", 32'(exp_rd0.size()), 32'h0);
        chk("err0_pending", 32'(exp_err0.size()), 32'h0);
        chk("wr3_pending", 32'(exp_wr3.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
